// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Time-shares one combinational ALU between two requesters (req0: switch
// panel, req1: scripted source). A round-robin grant picks a requester in
// IDLE. Its operands are registered onto the ALU inputs. After ALU_LAT
// cycles the ALU result is captured and returned on a valid/ready response
// channel. The last result is held on disp_value for the 7-segment display.
//
// Parameters:
//   ALU_LAT  cycles from operand register update to result capture (1..15)
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   reqN_valid/ready            per-requester handshake (ready is combinational)
//   reqN_a[7:0], reqN_b[4:0]    operands (b is zero-extended to 8 bits)
//   reqN_sel[2:0]               ALU operation select
//   alu_a/alu_b/alu_sel         registered operands driving the ALU
//   alu_r[7:0]                  combinational ALU result
//   rsp_valid/ready/id/data     response channel back to the issuing requester
//   disp_value[7:0]             last captured result
//   busy                        high whenever the sequencer is not idle
//
// Optional feature (macro ALU_SEQ_STATS_EN):
//   stat_cnt0/stat_cnt1[7:0]    saturating counts of completed responses per id
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [4:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [4:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_r,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic [7:0] disp_value,
    output logic       busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [7:0] stat_cnt0,
    output logic [7:0] stat_cnt1
`endif
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    // Counter is loaded with ALU_LAT-1 so capture lands exactly ALU_LAT
    // edges after the accept edge.
    localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       last_grant_r;
    logic [3:0] cnt_r;
    logic       grant0_s;
    logic       grant1_s;
    logic       accept0_s;
    logic       accept1_s;
    logic       rsp_done_s;

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    assign req0_ready = (state_r == IDLE) & grant0_s;
    assign req1_ready = (state_r == IDLE) & grant1_s;
    assign accept0_s  = req0_valid & req0_ready;
    assign accept1_s  = req1_valid & req1_ready;
    assign rsp_done_s = rsp_valid & rsp_ready;

    // Next-state decode for the IDLE -> WAIT -> RESP -> IDLE cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept0_s || accept1_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, operand, latency counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= 4'd0;
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_sel      <= 3'b000;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= 8'h00;
            disp_value   <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept0_s) begin
                        alu_a        <= req0_a;
                        alu_b        <= {3'b000, req0_b};
                        alu_sel      <= req0_sel;
                        rsp_id       <= 1'b0;
                        last_grant_r <= 1'b0;
                        cnt_r        <= CNT_LOAD;
                    end else if (accept1_s) begin
                        alu_a        <= req1_a;
                        alu_b        <= {3'b000, req1_b};
                        alu_sel      <= req1_sel;
                        rsp_id       <= 1'b1;
                        last_grant_r <= 1'b1;
                        cnt_r        <= CNT_LOAD;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        rsp_data   <= alu_r;
                        disp_value <= alu_r;
                        rsp_valid  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // Saturating per-requester counts of completed response handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt0 <= 8'h00;
            stat_cnt1 <= 8'h00;
        end else if (rsp_done_s) begin
            if (rsp_id == 1'b0) begin
                if (stat_cnt0 != 8'hFF) begin
                    stat_cnt0 <= stat_cnt0 + 8'd1;
                end else begin
                    stat_cnt0 <= stat_cnt0;
                end
            end else begin
                if (stat_cnt1 != 8'hFF) begin
                    stat_cnt1 <= stat_cnt1 + 8'd1;
                end else begin
                    stat_cnt1 <= stat_cnt1;
                end
            end
        end else begin
            stat_cnt0 <= stat_cnt0;
            stat_cnt1 <= stat_cnt1;
        end
    end
`else
    // Handshake decode only feeds the optional statistics counters.
    logic unused_rsp_done_s;
    assign unused_rsp_done_s = rsp_done_s;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req1_a;
    logic [4:0] req0_b, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic [7:0] alu_a, alu_b, alu_r;
    logic [2:0] alu_sel;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data, disp_value;

    // second instance built with ALU_LAT=4
    logic       l4_valid, l4_ready, l4_v1, l4_r1;
    logic [7:0] l4_a, l4_alu_a, l4_alu_b, l4_alu_r, l4_model;
    logic [4:0] l4_b;
    logic [2:0] l4_sel, l4_alu_sel;
    logic       l4_rsp_valid, l4_rsp_ready, l4_rsp_id, l4_busy, l4_corrupt;
    logic [7:0] l4_rsp_data, l4_disp;
    logic [7:0] zero8;
    logic [4:0] zero5;
    logic [2:0] zero3;

`ifdef ALU_SEQ_STATS_EN
    logic [7:0] stat_cnt0, stat_cnt1, l4_stat0, l4_stat1;
`endif

    int vectors;
    int miscompares;
    logic [8:0] sb[$];
    logic       acc0, acc1, rsp_seen;
    logic [8:0] rsp_got;
    logic [8:0] exp9;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {a[6:0], 1'b0};
            3'd6:    return {1'b0, a[7:1]};
            default: return b;
        endcase
    endfunction

    assign alu_r    = alu_model(alu_a, alu_b, alu_sel);
    assign l4_model = alu_model(l4_alu_a, l4_alu_b, l4_alu_sel);
    assign l4_alu_r = l4_corrupt ? ~l4_model : l4_model;

    alu_op_sequencer #(.ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .disp_value(disp_value), .busy(busy)
`ifdef ALU_SEQ_STATS_EN
        , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
    );

    alu_op_sequencer #(.ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(l4_valid), .req0_ready(l4_ready), .req0_a(l4_a),
        .req0_b(l4_b), .req0_sel(l4_sel),
        .req1_valid(l4_v1), .req1_ready(l4_r1), .req1_a(zero8),
        .req1_b(zero5), .req1_sel(zero3),
        .alu_a(l4_alu_a), .alu_b(l4_alu_b), .alu_sel(l4_alu_sel), .alu_r(l4_alu_r),
        .rsp_valid(l4_rsp_valid), .rsp_ready(l4_rsp_ready), .rsp_id(l4_rsp_id),
        .rsp_data(l4_rsp_data), .disp_value(l4_disp), .busy(l4_busy)
`ifdef ALU_SEQ_STATS_EN
        , .stat_cnt0(l4_stat0), .stat_cnt1(l4_stat1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: sample handshakes at negedge, push expectations on accept,
    // record any response handshake, then return 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (acc0) sb.push_back({1'b0, alu_model(req0_a, {3'b000, req0_b}, req0_sel)});
        if (acc1) sb.push_back({1'b1, alu_model(req1_a, {3'b000, req1_b}, req1_sel)});
        rsp_seen = rsp_valid & rsp_ready;
        rsp_got  = {rsp_id, rsp_data};
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_responses();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick();
            if (rsp_seen) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL drain_unexpected_rsp got=%h expected=none", rsp_got);
                end else begin
                    exp9 = sb.pop_front();
                    if (rsp_got !== exp9) begin
                        miscompares++;
                        $display("FAIL drain_rsp got=%h expected=%h", rsp_got, exp9);
                    end
                end
            end
        end
        vectors++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_timeout pending=%0d busy=%b expected 0/0", sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = 8'h00; req0_b = 5'h00; req0_sel = 3'b000;
        req1_a = 8'h00; req1_b = 5'h00; req1_sel = 3'b000;
        l4_valid = 1'b0; l4_v1 = 1'b0; l4_a = 8'h00; l4_b = 5'h00; l4_sel = 3'b000;
        l4_rsp_ready = 1'b0; l4_corrupt = 1'b0;
        zero8 = 8'h00; zero5 = 5'h00; zero3 = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, disp_value, busy,
             req0_ready, req1_ready} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got a=%h b=%h sel=%h v=%b id=%b d=%h disp=%h busy=%b expected all 0",
                     alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, disp_value, busy);
        end
        vectors++;
        if ({l4_rsp_valid, l4_busy, l4_disp} !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_lat4 got v=%b busy=%b disp=%h expected 0", l4_rsp_valid, l4_busy, l4_disp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req0_a = 8'h12; req0_b = 5'h03; req0_sel = 3'b000; req0_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_ready got=%b%b expected=10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        vectors++;
        if (acc0 !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept got acc=%b v=%b busy=%b expected 1/0/1", acc0, rsp_valid, busy);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data, disp_value} !== {1'b1, 1'b0, 8'h15, 8'h15}) begin
            miscompares++;
            $display("FAIL single_rsp got v=%b id=%b d=%h disp=%h expected 1/0/15/15",
                     rsp_valid, rsp_id, rsp_data, disp_value);
        end
        rsp_ready = 1'b1;
        tick();
        vectors++;
        if (!rsp_seen || sb.size() == 0) begin
            miscompares++;
            $display("FAIL single_handshake got seen=%b pending=%0d expected 1/1", rsp_seen, sb.size());
        end else begin
            exp9 = sb.pop_front();
            if (rsp_got !== exp9) begin
                miscompares++;
                $display("FAIL single_sb got=%h expected=%h", rsp_got, exp9);
            end
        end
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle got v=%b busy=%b expected 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] held;
        bit got;
        rsp_ready = 1'b0;
        req0_a = 8'h80; req0_b = 5'h1F; req0_sel = 3'b001; req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            got = acc0;
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 5 && !rsp_valid; i++) tick();
        vectors++;
        if (!got || rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_setup got acc=%b v=%b expected 1/1", got, rsp_valid);
        end
        held = {rsp_id, rsp_data};
        req0_a = 8'h0F; req0_b = 5'h01; req0_sel = 3'b100; req0_valid = 1'b1;
        req1_a = 8'hC3; req1_b = 5'h10; req1_sel = 3'b010; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++;
            if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100 ||
                {rsp_id, rsp_data} !== held || held !== {1'b0, 8'h61}) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d got v=%b busy=%b rdy=%b%b rsp=%h expected 1/1/00/061",
                         i, rsp_valid, busy, req0_ready, req1_ready, {rsp_id, rsp_data});
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        vectors++;
        if (!rsp_seen || acc0 || acc1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL bp_release got seen=%b acc=%b%b expected 1/00", rsp_seen, acc0, acc1);
        end else begin
            exp9 = sb.pop_front();
            if (rsp_got !== exp9) begin
                miscompares++;
                $display("FAIL bp_sb got=%h expected=%h", rsp_got, exp9);
            end
        end
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_next_grant got=%b%b expected=01", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain_responses();
    endtask

    task automatic test_tie();
        int ops;
        apply_reset();
        rsp_ready = 1'b1;
        ops = 0;
        req0_a = 8'h21; req0_b = 5'h05; req0_sel = 3'b000; req0_valid = 1'b1;
        req1_a = 8'h9A; req1_b = 5'h0C; req1_sel = 3'b001; req1_valid = 1'b1;
        for (int c = 0; c < 40 && ops < 4; c++) begin
            tick();
            if (rsp_seen) begin
                vectors++;
                exp9 = (sb.size() != 0) ? sb.pop_front() : 9'h1FF;
                if (rsp_got !== exp9) begin
                    miscompares++;
                    $display("FAIL tie_rsp got=%h expected=%h", rsp_got, exp9);
                end
            end
            if (acc0 || acc1) begin
                vectors++;
                if ({acc0, acc1} !== ((ops % 2 == 0) ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL tie_order op=%0d got=%b%b expected=%0d", ops, acc0, acc1, ops % 2);
                end
                ops++;
                if (acc0) begin req0_a = req0_a + 8'h37; req0_sel = req0_sel + 3'd3; end
                if (acc1) begin req1_b = req1_b + 5'h07; req1_sel = req1_sel + 3'd5; end
                if (ops == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        vectors++;
        if (ops != 4) begin
            miscompares++;
            $display("FAIL tie_count got=%0d expected=4", ops);
        end
        drain_responses();
    endtask

    task automatic test_reset_mid_wait();
        bit got, any_rsp;
        rsp_ready = 1'b1;
        req1_a = 8'h44; req1_b = 5'h02; req1_sel = 3'b011; req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            got = acc1;
        end
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (!got || {alu_a, alu_b, alu_sel, rsp_valid, rsp_data, disp_value, busy} !== 38'h0) begin
            miscompares++;
            $display("FAIL midreset_async got acc=%b a=%h v=%b disp=%h busy=%b expected 1/0/0/0/0",
                     got, alu_a, rsp_valid, disp_value, busy);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        any_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_rsp = any_rsp | rsp_valid;
        end
        vectors++;
        if (any_rsp !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_rsp got=%b expected=0", any_rsp);
        end
        req0_a = 8'hF0; req0_b = 5'h11; req0_sel = 3'b110; req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL midreset_tie got=%b%b expected=10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain_responses();
    endtask

    task automatic test_latency4();
        l4_a = 8'h35; l4_b = 5'h0A; l4_sel = 3'b000; l4_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (l4_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL lat4_ready got=%b expected=1", l4_ready);
        end
        @(posedge clk);
        #1;
        l4_valid = 1'b0;
        l4_corrupt = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (l4_rsp_valid !== 1'b0 || l4_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL lat4_early k=%0d got v=%b busy=%b expected 0/1", k, l4_rsp_valid, l4_busy);
            end
            if (k == 3) l4_corrupt = 1'b0;
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({l4_rsp_valid, l4_rsp_id, l4_rsp_data, l4_disp} !== {1'b1, 1'b0, 8'h3F, 8'h3F}) begin
            miscompares++;
            $display("FAIL lat4_capture got v=%b id=%b d=%h disp=%h expected 1/0/3f/3f",
                     l4_rsp_valid, l4_rsp_id, l4_rsp_data, l4_disp);
        end
        l4_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        l4_rsp_ready = 1'b0;
        vectors++;
        if (l4_rsp_valid !== 1'b0 || l4_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL lat4_done got v=%b busy=%b expected 0/0", l4_rsp_valid, l4_busy);
        end
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        int done;
        apply_reset();
        rsp_ready = 1'b1;
        req1_a = 8'h01; req1_b = 5'h01; req1_sel = 3'b000; req1_valid = 1'b1;
        done = 0;
        for (int c = 0; c < 1200 && done < 300; c++) begin
            tick();
            if (rsp_seen) done++;
        end
        req1_valid = 1'b0;
        sb.delete();
        repeat (3) tick();
        vectors++;
        if (done != 300 || stat_cnt1 !== 8'hFF || stat_cnt0 !== 8'h00) begin
            miscompares++;
            $display("FAIL stats got ops=%0d cnt1=%h cnt0=%h expected 300/ff/00", done, stat_cnt1, stat_cnt0);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_tie();
        test_reset_mid_wait();
        test_latency4();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
